// File: rtl/axis_pkt_arbiter_if.sv
// Stream bundle between the packet arbiter and its environment: NUM_SRC source lanes in, one tagged lane out.
// The master modport is the arbiter's view; the slave modport is the sources-plus-sink side.
interface axis_pkt_arbiter_if #(
  parameter int DW      = 8,
  parameter int NUM_SRC = 4
);
  localparam int IDW = $clog2(NUM_SRC);

  logic [NUM_SRC*DW-1:0] s_tdata;
  logic [NUM_SRC-1:0]    s_tvalid;
  logic [NUM_SRC-1:0]    s_tlast;
  logic [NUM_SRC-1:0]    s_tready;

  logic [DW-1:0]         m_tdata;
  logic                  m_tvalid;
  logic                  m_tlast;
  logic [IDW-1:0]        m_tid;
  logic                  m_tready;

  modport master (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );

  modport slave (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: NUM_SRC AXI-Stream sources share one registered output stage,
// the grant is locked from first beat to tlast so packets never interleave.
//
// state | meaning
// IDLE  | no grant held; pick next requester after rr_ptr, no beat accepted
// BUSY  | grant_q owns the output until its tlast beat is accepted
module axis_pkt_arbiter #(
  parameter int DW      = 8,
  parameter int NUM_SRC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  axis_pkt_arbiter_if.master   bus,
  output logic                 busy
);
  localparam int IDW = $clog2(NUM_SRC);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DW-1:0]        m_tdata_q, m_tdata_d;
  logic                 m_tvalid_q, m_tvalid_d;
  logic                 m_tlast_q, m_tlast_d;
  logic [IDW-1:0]       m_tid_q, m_tid_d;
  logic [NUM_SRC-1:0]   s_tready_c;
  logic                 out_free;

  // First requester strictly after ptr, wrapping modulo NUM_SRC.
  function automatic logic [IDW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                             input logic [IDW-1:0]     ptr);
    logic [IDW-1:0] pick;
    logic           found;
    int             idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(ptr) + k) % NUM_SRC;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
    return pick;
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    m_tdata_d  = m_tdata_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tid_d    = m_tid_q;
    s_tready_c = '0;
    out_free   = ~m_tvalid_q | bus.m_tready;

    if (m_tvalid_q && bus.m_tready) begin
      m_tvalid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (|bus.s_tvalid) begin
          grant_d = rr_pick(bus.s_tvalid, rr_ptr_q);
          state_d = BUSY;
        end
      end
      BUSY: begin
        s_tready_c[grant_q] = out_free;
        // An accepted beat overrides the drain above, keeping 1 beat/cycle.
        if (bus.s_tvalid[grant_q] && out_free) begin
          m_tdata_d  = bus.s_tdata[int'(grant_q)*DW +: DW];
          m_tlast_d  = bus.s_tlast[grant_q];
          m_tid_d    = grant_q;
          m_tvalid_d = 1'b1;
          if (bus.s_tlast[grant_q]) begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IDW'(NUM_SRC - 1);
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tid_q    <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tid_q    <= m_tid_d;
    end
  end

  assign bus.s_tready = s_tready_c;
  assign bus.m_tdata  = m_tdata_q;
  assign bus.m_tvalid = m_tvalid_q;
  assign bus.m_tlast  = m_tlast_q;
  assign bus.m_tid    = m_tid_q;
  assign busy         = (state_q == BUSY);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: per-source packet queues, a packet-level reference model checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_axis_pkt_arbiter;
  localparam int DW = 8;
  localparam int NS = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  axis_pkt_arbiter_if #(.DW(DW), .NUM_SRC(NS)) bus ();

  axis_pkt_arbiter #(.DW(DW), .NUM_SRC(NS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       last;
    int         cyc;
  } beat_t;

  beat_t      got[$];
  logic [8:0] srcq[NS][$];
  logic [NS-1:0] stall;
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: owner of the output (-1 when nobody holds it), last winner, and the output register.
  int         md_owner;
  int         md_last;
  logic       e_valid;
  logic [7:0] e_data;
  logic       e_last;
  int         e_id;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [NS-1:0] req, input int last);
    for (int k = 1; k <= NS; k++) begin
      if (req[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  task automatic model_reset();
    md_owner = -1;
    md_last  = NS - 1;
    e_valid  = 1'b0;
    e_data   = 8'h00;
    e_last   = 1'b0;
    e_id     = 0;
  endtask

  task automatic drive();
    logic [8:0] b;
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0 && !stall[i]) begin
        b = srcq[i][0];
        bus.s_tvalid[i]          = 1'b1;
        bus.s_tdata[i*DW +: DW]  = b[7:0];
        bus.s_tlast[i]           = b[8];
      end else begin
        bus.s_tvalid[i]          = 1'b0;
        bus.s_tdata[i*DW +: DW]  = 8'h00;
        bus.s_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic load(input int s, input int n, input int base);
    for (int b = 0; b < n; b++) begin
      srcq[s].push_back({(b == n - 1) ? 1'b1 : 1'b0, 8'(base + b)});
    end
  endtask

  // One clock: compare at the falling edge, advance the model, then update sources after the rising edge.
  task automatic step();
    logic [NS-1:0] hs;
    logic [NS-1:0] exp_rdy;
    beat_t         bt;
    logic          free;
    hs = '0;
    @(negedge clk);
    cyc++;
    if (rst_n) begin
      exp_rdy = '0;
      if (md_owner >= 0 && (!e_valid || bus.m_tready)) exp_rdy[md_owner] = 1'b1;
      chk("s_tready", 32'(bus.s_tready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(md_owner >= 0));
      chk("m_tvalid", 32'(bus.m_tvalid), 32'(e_valid));
      if (e_valid) begin
        chk("m_tdata", 32'(bus.m_tdata), 32'(e_data));
        chk("m_tlast", 32'(bus.m_tlast), 32'(e_last));
        chk("m_tid", 32'(bus.m_tid), 32'(e_id));
      end
      hs = bus.s_tvalid & bus.s_tready;
      if (bus.m_tvalid && bus.m_tready) begin
        bt.id = int'(bus.m_tid); bt.data = bus.m_tdata; bt.last = bus.m_tlast; bt.cyc = cyc;
        got.push_back(bt);
      end
      if (md_owner < 0) begin
        if (e_valid && bus.m_tready) e_valid = 1'b0;
        md_owner = pick(bus.s_tvalid, md_last);
      end else begin
        free = !e_valid || bus.m_tready;
        if (bus.s_tvalid[md_owner] && free) begin
          e_valid = 1'b1;
          e_data  = bus.s_tdata[md_owner*DW +: DW];
          e_last  = bus.s_tlast[md_owner];
          e_id    = md_owner;
          if (e_last) begin
            md_last  = md_owner;
            md_owner = -1;
          end
        end else if (e_valid && bus.m_tready) begin
          e_valid = 1'b0;
        end
      end
    end else begin
      model_reset();
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    drive();
  endtask

  task automatic run_until(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(name, 32'(got.size()), 32'(n));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    stall = '0;
    bus.m_tready = 1'b1;
    drive();
    got.delete();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    int c0;
    int k;
    rst_n        = 1'b0;
    bus.s_tdata  = '0;
    bus.s_tvalid = '0;
    bus.s_tlast  = '0;
    bus.m_tready = 1'b1;
    stall        = '0;
    model_reset();
    step();
    step();
    chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("rst_m_tdata", 32'(bus.m_tdata), 32'd0);
    chk("rst_m_tlast", 32'(bus.m_tlast), 32'd0);
    chk("rst_m_tid", 32'(bus.m_tid), 32'd0);
    chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;

    // Reset mid-stream, then a 4-way simultaneous request must go to source 0 first.
    for (int i = 0; i < NS; i++) load(i, 4, 16 * i);
    drive();
    run_until(1, 20, "t1_first_beat");
    chk("t1_pre_rst_valid", 32'(bus.m_tvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_m_tvalid", 32'(bus.m_tvalid), 32'd0);
    chk("t1_rst_s_tready", 32'(bus.s_tready), 32'd0);
    for (int i = 0; i < NS; i++) srcq[i].delete();
    got.delete();
    for (int i = 0; i < NS; i++) load(i, 1, 8'h10 + i);
    drive();
    step();
    step();
    rst_n = 1'b1;
    run_until(4, 40, "t1_beats");
    for (int i = 0; i < got.size() && i < 4; i++) chk("t1_order", 32'(got[i].id), 32'(i));

    // Single source 3-beat packet, latency and back-to-back beats.
    do_reset();
    load(2, 3, 8'hA0);
    drive();
    c0 = cyc + 1;
    run_until(3, 20, "t2_beats");
    if (got.size() == 3) begin
      chk("t2_latency", 32'(got[0].cyc - c0), 32'd2);
      chk("t2_consec1", 32'(got[1].cyc - got[0].cyc), 32'd1);
      chk("t2_consec2", 32'(got[2].cyc - got[1].cyc), 32'd1);
      for (int i = 0; i < 3; i++) begin
        chk("t2_data", 32'(got[i].data), 32'(8'hA0 + i));
        chk("t2_tid", 32'(got[i].id), 32'd2);
        chk("t2_last", 32'(got[i].last), 32'(i == 2));
      end
    end

    // Fairness: every source streams three 2-beat packets.
    do_reset();
    for (int s = 0; s < NS; s++)
      for (int p = 0; p < 3; p++) load(s, 2, 16 * s + 2 * p);
    drive();
    run_until(24, 200, "t3_beats");
    for (int i = 0; i < got.size() && i < 24; i++) begin
      chk("t3_tid", 32'(got[i].id), 32'((i / 2) % NS));
      chk("t3_data", 32'(got[i].data), 32'(16 * ((i / 2) % NS) + 2 * (i / 8) + (i % 2)));
      chk("t3_last", 32'(got[i].last), 32'(i % 2));
    end

    // Backpressure for 5 cycles mid-packet.
    do_reset();
    load(1, 6, 8'h40);
    drive();
    run_until(2, 20, "t4_pre");
    bus.m_tready = 1'b0;
    chk("t4_hold_valid", 32'(bus.m_tvalid), 32'd1);
    chk("t4_hold_data0", 32'(bus.m_tdata), 32'h42);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_hold_data", 32'(bus.m_tdata), 32'h42);
      chk("t4_hold_last", 32'(bus.m_tlast), 32'd0);
      chk("t4_hold_tid", 32'(bus.m_tid), 32'd1);
      chk("t4_hold_rdy", 32'(bus.s_tready), 32'd0);
    end
    bus.m_tready = 1'b1;
    run_until(6, 30, "t4_beats");
    for (int i = 0; i < got.size() && i < 6; i++) begin
      chk("t4_data", 32'(got[i].data), 32'(8'h40 + i));
      chk("t4_last", 32'(got[i].last), 32'(i == 5));
    end

    // Granted source stalls mid-packet while another source waits.
    do_reset();
    load(1, 4, 8'h50);
    drive();
    k = 0;
    while (srcq[1].size() > 2 && k < 20) begin
      step();
      k++;
    end
    chk("t5_two_taken", 32'(srcq[1].size()), 32'd2);
    stall[1] = 1'b1;
    load(3, 2, 8'h70);
    drive();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_lock_rdy", 32'(bus.s_tready), 32'b0010);
      chk("t5_lock_busy", 32'(busy), 32'd1);
    end
    stall[1] = 1'b0;
    drive();
    run_until(6, 40, "t5_beats");
    for (int i = 0; i < got.size() && i < 6; i++) begin
      chk("t5_tid", 32'(got[i].id), (i < 4) ? 32'd1 : 32'd3);
      chk("t5_data", 32'(got[i].data), (i < 4) ? 32'(8'h50 + i) : 32'(8'h70 + i - 4));
    end

    // Back-to-back single-beat packets with one arbitration bubble.
    do_reset();
    load(0, 1, 8'h60);
    load(1, 1, 8'h61);
    drive();
    c0 = cyc + 1;
    run_until(2, 20, "t6_beats");
    if (got.size() == 2) begin
      chk("t6_tid0", 32'(got[0].id), 32'd0);
      chk("t6_tid1", 32'(got[1].id), 32'd1);
      chk("t6_last0", 32'(got[0].last), 32'd1);
      chk("t6_last1", 32'(got[1].last), 32'd1);
      chk("t6_latency", 32'(got[0].cyc - c0), 32'd2);
      chk("t6_gap", 32'(got[1].cyc - got[0].cyc), 32'd2);
    end
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
